// File: rtl/rho_rotate_controller_if.sv
// Bus between the rho controller, the round FSM and the two state memories.
// The controller side is the master modport; the environment side is the slave.
interface rho_rotate_controller_if #(
  parameter int LANES = 25,
  parameter int ZW    = 6
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [ZW-1:0]    rd_addr;
  logic [LANES-1:0] rd_data;
  logic             wr_en;
  logic [4:0]       wr_lane;
  logic [ZW-1:0]    wr_z;
  logic             wr_bit;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_lane, wr_z, wr_bit
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_lane, wr_z, wr_bit
  );
endinterface

// File: rtl/rho_rotate_controller.sv
// Rho step sequencer: reads each of the 64 source slices once and scatters its
// 25 lane bits as single-bit writes at z' = z + r[x][y] (mod 64).
module rho_rotate_controller #(
  parameter int LANES  = 25,
  parameter int SLICES = 64,
  parameter int ZW     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  rho_rotate_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    ROTATE,
    DONE
  } state_t;

  localparam logic [4:0]    LAST_LANE  = 5'(LANES - 1);
  localparam logic [ZW-1:0] LAST_SLICE = ZW'(SLICES - 1);

  state_t           state;
  logic [ZW-1:0]    z;
  logic [4:0]       lane;
  logic [LANES-1:0] slice_reg;

  // Offset ROM flattened into lane order i, with x=((i%5)+3)%5, y=((i/5)+3)%5
  // already folded in, so lane 12 (x=0, y=0) carries offset 0.
  function automatic logic [ZW-1:0] lane_offset(input logic [4:0] i);
    case (i)
      5'd0:    lane_offset = ZW'(21);
      5'd1:    lane_offset = ZW'(8);
      5'd2:    lane_offset = ZW'(41);
      5'd3:    lane_offset = ZW'(45);
      5'd4:    lane_offset = ZW'(15);
      5'd5:    lane_offset = ZW'(56);
      5'd6:    lane_offset = ZW'(14);
      5'd7:    lane_offset = ZW'(18);
      5'd8:    lane_offset = ZW'(2);
      5'd9:    lane_offset = ZW'(61);
      5'd10:   lane_offset = ZW'(28);
      5'd11:   lane_offset = ZW'(27);
      5'd12:   lane_offset = ZW'(0);
      5'd13:   lane_offset = ZW'(1);
      5'd14:   lane_offset = ZW'(62);
      5'd15:   lane_offset = ZW'(55);
      5'd16:   lane_offset = ZW'(20);
      5'd17:   lane_offset = ZW'(36);
      5'd18:   lane_offset = ZW'(44);
      5'd19:   lane_offset = ZW'(6);
      5'd20:   lane_offset = ZW'(25);
      5'd21:   lane_offset = ZW'(39);
      5'd22:   lane_offset = ZW'(3);
      5'd23:   lane_offset = ZW'(10);
      5'd24:   lane_offset = ZW'(43);
      default: lane_offset = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      z         <= '0;
      lane      <= '0;
      // NOTE: slice_reg is a single register rather than a memory array, so it is cleared by reset.
      slice_reg <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      case (state)
        IDLE: begin
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          slice_reg <= bus.rd_data;
          lane      <= '0;
          state     <= ROTATE;
        end
        ROTATE: begin
          if (lane == LAST_LANE) begin
            if (z == LAST_SLICE) begin
              state <= DONE;
            end else begin
              z     <= z + 1'b1;
              state <= FETCH;
            end
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DONE: begin
          z     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state and counters; the ZW-bit sum drops its carry.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_lane = '0;
    bus.wr_z    = '0;
    bus.wr_bit  = 1'b0;
    case (state)
      FETCH: begin
        bus.busy    = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = z;
      end
      CAPTURE: begin
        bus.busy = 1'b1;
      end
      ROTATE: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_lane = lane;
        bus.wr_z    = z + lane_offset(lane);
        bus.wr_bit  = slice_reg[lane];
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rho_rotate_controller.sv
// Bench for rho_rotate_controller: timeline model of a pass, a destination
// scoreboard checked against a reference rho, and directed scenario checks.
module tb_rho_rotate_controller;

  localparam int PASS_LAST = 64 * 27;   // model time index of the DONE cycle

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rho_rotate_controller_if #(.LANES(25), .ZW(6)) bus ();

  rho_rotate_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [24:0] src [64];
  int          checks   = 0;
  int          failures = 0;
  int          t        = -1;
  int          cyc      = 0;

  bit          dest    [25][64];
  bit          written [25][64];
  int          writes, dups, done_cnt = 0;
  int          last_done_cyc = -1, gap = -1, dut_fetch_cyc = 0;
  logic        busy_at_done;
  logic [10:0] ones_q [$];

  int rho_tab [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  function automatic int rho_off(input int i);
    int x, y;
    x = ((i % 5) + 3) % 5;
    y = ((i / 5) + 3) % 5;
    return rho_tab[x][y];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0d cyc=%0d)", name, act, exp, t, cyc);
    end
  endtask

  function automatic logic [21:0] out_vec();
    return {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.wr_en,
            bus.wr_lane, bus.wr_z, bus.wr_bit};
  endfunction

  // Expected outputs from the position t inside a pass: 27 cycles per slice,
  // phase 0 reads, phase 1 captures, phases 2..26 write lanes 0..24.
  function automatic logic [21:0] expected_vec();
    logic       e_busy, e_done, e_rd, e_wr, e_bit;
    logic [5:0] e_addr, e_z;
    logic [4:0] e_lane;
    int         s, ph, ln;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_bit = 0;
    e_addr = 0; e_z = 0; e_lane = 0;
    if (!rst && t >= 0) begin
      if (t == PASS_LAST) begin
        e_done = 1;
      end else begin
        s      = t / 27;
        ph     = t % 27;
        e_busy = 1;
        if (ph == 0) begin
          e_rd   = 1;
          e_addr = 6'(s);
        end else if (ph >= 2) begin
          ln     = ph - 2;
          e_wr   = 1;
          e_lane = 5'(ln);
          e_z    = 6'((s + rho_off(ln)) % 64);
          e_bit  = src[s][ln];
        end
      end
    end
    return {e_busy, e_done, e_rd, e_addr, e_wr, e_lane, e_z, e_bit};
  endfunction

  // Synchronous-read source memory.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pass timeline model: idle (-1) until start is seen, then counts to DONE.
  always @(posedge clk or posedge rst) begin
    if (rst)                  t <= -1;
    else if (t < 0)           t <= bus.start ? 0 : -1;
    else if (t == PASS_LAST)  t <= -1;
    else                      t <= t + 1;
  end

  always @(negedge clk) begin
    int bad, zd;
    check("outputs", longint'(out_vec()), longint'(expected_vec()));
    if (!rst) begin
      if (bus.rd_en && bus.rd_addr == 6'd0) begin
        writes = 0;
        dups   = 0;
        ones_q.delete();
        foreach (written[l, z]) begin
          written[l][z] = 0;
          dest[l][z]    = 0;
        end
        dut_fetch_cyc = cyc;
        if (last_done_cyc >= 0) gap = cyc - last_done_cyc;
      end
      if (bus.wr_en && bus.wr_lane < 5'd25) begin
        if (written[bus.wr_lane][bus.wr_z]) dups++;
        written[bus.wr_lane][bus.wr_z] = 1;
        dest[bus.wr_lane][bus.wr_z]    = bus.wr_bit;
        writes++;
        if (bus.wr_bit) ones_q.push_back({bus.wr_lane, bus.wr_z});
      end
      if (bus.done) begin
        check("write_count", writes, 1600);
        check("dup_pairs", dups, 0);
        bad = 0;
        for (int l = 0; l < 25; l++) begin
          for (int z = 0; z < 64; z++) begin
            zd = (z + rho_off(l)) % 64;
            if (dest[l][zd] !== src[z][l]) bad++;
          end
        end
        check("dest_state", bad, 0);
        check("fetch_to_done", cyc - dut_fetch_cyc, PASS_LAST);
        done_cnt++;
        busy_at_done  = bus.busy;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); #2;
    bus.start = 1'b1;
    @(negedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, longint'(done_cnt != d0), 1);
  endtask

  task automatic wait_t(input string name, input int target);
    int n = 0;
    while (t != target && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_reached"}, t, target);
  endtask

  initial begin
    int d0, d1;
    rst       = 1'b1;
    bus.start = 1'b0;
    foreach (src[z]) src[z] = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_outputs", longint'(out_vec()), 0);

    // Single bit in slice 0, lane 0 lands at z'=21.
    src[0] = 25'h0000001;
    d0 = done_cnt;
    pulse_start();
    wait_done("p1");
    check("p1_done_pulses", done_cnt - d0, 1);
    check("p1_busy_at_done", longint'(busy_at_done), 0);
    check("p1_ones", ones_q.size(), 1);
    check("p1_one_pos", longint'(ones_q[0]), longint'({5'd0, 6'd21}));
    repeat (3) @(negedge clk);

    // Slice 63: lane 7 wraps to z'=17, lane 12 stays at z'=63.
    src[0]  = '0;
    src[63] = 25'h0001080;
    pulse_start();
    wait_done("p2");
    check("p2_ones", ones_q.size(), 2);
    check("p2_lane7_pos", longint'(ones_q[0]), longint'({5'd7, 6'd17}));
    check("p2_lane12_pos", longint'(ones_q[1]), longint'({5'd12, 6'd63}));
    repeat (3) @(negedge clk);

    // Full random state.
    foreach (src[z]) src[z] = 25'($urandom());
    pulse_start();
    wait_done("p3");
    repeat (3) @(negedge clk);

    // Start pulsed mid-pass is ignored.
    d0 = done_cnt;
    pulse_start();
    wait_t("p4_mid", 100);
    bus.start = 1'b1;
    @(negedge clk); #2;
    bus.start = 1'b0;
    wait_done("p4");
    check("p4_done_pulses", done_cnt - d0, 1);
    d1 = done_cnt;
    repeat (40) @(negedge clk);
    #1;
    check("p4_no_restart", done_cnt - d1, 0);

    // Start held high: back-to-back passes with one idle cycle between.
    @(negedge clk); #2;
    bus.start = 1'b1;
    wait_done("p5a");
    repeat (2) @(negedge clk);
    #1;
    check("p5_done_to_fetch_gap", gap, 2);
    bus.start = 1'b0;
    wait_done("p5b");
    repeat (3) @(negedge clk);

    // Reset during ROTATE of slice 30, then a clean full pass.
    foreach (src[z]) src[z] = 25'($urandom());
    pulse_start();
    wait_t("p6_slice30", 30 * 27 + 12);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", longint'(out_vec()), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    pulse_start();
    check("restart_fetch", longint'({bus.rd_en, bus.rd_addr}), longint'(7'b1000000));
    wait_done("p6");
    check("p6_done_pulses", done_cnt - d0, 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
